// File: rtl/mux_arbiter.sv
// mux_arbiter: 4-source round-robin arbiter feeding a registered output mux.
// A grant captures the winning source's data and holds it until the consumer
// takes it with out_ready.
// Optional feature: define MUX_ARBITER_TIMEOUT_EN to drop a grant that has
// stalled for TMO cycles. The drop pulses timeout and produces no ack.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no grant outstanding; arbitrate on any nonzero req
// HOLD  | grant outstanding; sel/out_data frozen until accepted or dropped
module mux_arbiter #(
  parameter int DW  = 2,
  parameter int TMO = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3:0]    req,
  input  logic [DW-1:0] x0,
  input  logic [DW-1:0] x1,
  input  logic [DW-1:0] x2,
  input  logic [DW-1:0] x3,
  output logic [1:0]    sel,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  output logic [3:0]    ack,
  output logic          timeout
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t        state, state_nxt;
  logic [1:0]    last, last_nxt;
  logic [1:0]    sel_nxt;
  logic [1:0]    winner;
  logic          valid_nxt;
  logic [DW-1:0] data_nxt;
  logic [DW-1:0] x_win;

`ifdef MUX_ARBITER_TIMEOUT_EN
  localparam logic [7:0] TMO_C = 8'(TMO);
  logic [7:0] stall, stall_nxt;
  logic       tmo_nxt;
`else
  logic [7:0] unused_tmo;
  assign unused_tmo = 8'(TMO);
  assign timeout    = 1'b0;
`endif

  // Round-robin search upward from last+1. Descending the loop lets the closest candidate win.
  always_comb begin
    winner = last;
    for (int i = 4; i >= 1; i--) begin
      if (req[2'(last + 2'(i))]) winner = 2'(last + 2'(i));
    end
  end

  // Data mux for the winning source.
  always_comb begin
    case (winner)
      2'd0:    x_win = x0;
      2'd1:    x_win = x1;
      2'd2:    x_win = x2;
      default: x_win = x3;
    endcase
  end

  // Next-state and datapath decisions. Registers hold by default.
  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    data_nxt  = out_data;
    valid_nxt = out_valid;
    last_nxt  = last;
`ifdef MUX_ARBITER_TIMEOUT_EN
    stall_nxt = stall;
    tmo_nxt   = 1'b0;
`endif
    case (state)
      IDLE: begin
        valid_nxt = 1'b0;
        if (req != 4'b0000) begin
          sel_nxt   = winner;
          data_nxt  = x_win;
          valid_nxt = 1'b1;
          state_nxt = HOLD;
`ifdef MUX_ARBITER_TIMEOUT_EN
          stall_nxt = 8'd0;
`endif
        end
      end
      HOLD: begin
        // An accept on the limit edge wins over the drop, because the ack has already been seen.
        if (out_ready) begin
          valid_nxt = 1'b0;
          last_nxt  = sel;
          state_nxt = IDLE;
        end
`ifdef MUX_ARBITER_TIMEOUT_EN
        else if (stall == TMO_C) begin
          valid_nxt = 1'b0;
          last_nxt  = sel;
          tmo_nxt   = 1'b1;
          state_nxt = IDLE;
        end else begin
          stall_nxt = stall + 8'd1;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Datapath registers. last resets to 3 so the first search starts at source 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel       <= 2'd0;
      out_data  <= '0;
      out_valid <= 1'b0;
      last      <= 2'd3;
    end else begin
      sel       <= sel_nxt;
      out_data  <= data_nxt;
      out_valid <= valid_nxt;
      last      <= last_nxt;
    end
  end

`ifdef MUX_ARBITER_TIMEOUT_EN
  // Stall counter and the one-cycle timeout pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall   <= 8'd0;
      timeout <= 1'b0;
    end else begin
      stall   <= stall_nxt;
      timeout <= tmo_nxt;
    end
  end
`endif

  // Combinational one-hot ack at the granted index when the consumer accepts.
  always_comb begin
    ack = 4'b0000;
    if (out_valid && out_ready) ack[sel] = 1'b1;
  end

endmodule

// File: tb/tb_mux_arbiter.sv
// Self-checking bench for mux_arbiter.
// Build with MUX_ARBITER_TIMEOUT_EN defined to exercise the stall timeout as well.
module tb_mux_arbiter;
  localparam int DW  = 2;
  localparam int TMO = 15;

  logic          clk;
  logic          rst_n;
  logic [3:0]    req;
  logic [DW-1:0] xs [4];
  logic [1:0]    sel;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic [3:0]    ack;
  logic          timeout;

  mux_arbiter #(.DW(DW), .TMO(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .x0(xs[0]), .x1(xs[1]), .x2(xs[2]), .x3(xs[3]),
    .sel(sel), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .ack(ack), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_no = 0;

  // Reference model: one outstanding transfer record plus a round-robin pointer.
  bit m_valid;
  int m_sel, m_data, m_last, m_cnt;
  bit m_tmo;

  int ack_data[$];
  int ack_time[$];
  int ack_vec[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc_no);
    end
  endtask

  function automatic void model_reset();
    m_valid = 0; m_sel = 0; m_data = 0; m_last = 3; m_cnt = 0; m_tmo = 0;
  endfunction

  task automatic model_step();
    bit nxt_tmo;
    nxt_tmo = 0;
    if (m_valid) begin
      if (out_ready) begin
        m_valid = 0; m_last = m_sel;
      end
`ifdef MUX_ARBITER_TIMEOUT_EN
      else if (m_cnt == TMO) begin
        m_valid = 0; m_last = m_sel; nxt_tmo = 1;
      end else begin
        m_cnt++;
      end
`endif
    end else if (req != 4'b0000) begin
      for (int j = 1; j <= 4; j++) begin
        int k;
        k = (m_last + j) % 4;
        if (req[k]) begin
          m_sel = k; m_data = int'(xs[k]); m_valid = 1; m_cnt = 0;
          break;
        end
      end
    end
    m_tmo = nxt_tmo;
  endtask

  // Apply inputs (at negedge), settle, and compare every output with the model.
  task automatic drive(input logic [3:0] r, input logic rdy);
    int exp_ack;
    req = r; out_ready = rdy;
    #1;
    exp_ack = (m_valid && rdy) ? (1 << m_sel) : 0;
    check("sel", 32'(sel), 32'(m_sel));
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("out_data", 32'(out_data), 32'(m_data));
    check("ack", 32'(ack), 32'(exp_ack));
    check("timeout", 32'(timeout), 32'(m_tmo));
    if (ack != 4'b0000) begin
      ack_data.push_back(int'(out_data));
      ack_time.push_back(cyc_no);
      ack_vec.push_back(int'(ack));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    else       model_reset();
    @(negedge clk);
    cyc_no++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic clear_log();
    ack_data.delete(); ack_time.delete(); ack_vec.delete();
  endtask

  initial begin
    int n;
    rst_n = 1'b0; req = 4'b0000; out_ready = 1'b0;
    for (int i = 0; i < 4; i++) xs[i] = '0;
    model_reset();
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single requester 0, one-cycle latency, one-cycle ack.
    xs[0] = 2'b10;
    drive(4'b0001, 1'b1); tick();
    drive(4'b0000, 1'b1);
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_sel", 32'(sel), 32'd0);
    check("t1_data", 32'(out_data), 32'd2);
    check("t1_ack", 32'(ack), 32'b0001);
    tick();
    drive(4'b0000, 1'b1);
    check("t1_ack_once", 32'(ack), 32'd0);
    tick();

    // All four requesting: data 0,1,2,3,0 at 2-cycle spacing.
    do_reset();
    for (int i = 0; i < 4; i++) xs[i] = DW'(i);
    clear_log();
    for (int i = 0; i < 12; i++) begin drive(4'b1111, 1'b1); tick(); end
    check("rr_count", 32'(ack_data.size() >= 5), 32'd1);
    if (ack_data.size() >= 5) begin
      for (int i = 0; i < 5; i++) begin
        check("rr_data", 32'(ack_data[i]), 32'(i % 4));
        if (i > 0) check("rr_spacing", 32'(ack_time[i] - ack_time[i-1]), 32'd2);
      end
    end

    // Granted source 2 stalls for 5 cycles while its data toggles.
    drive(4'b0000, 1'b0); tick();
    xs[2] = 2'b01;
    drive(4'b0100, 1'b0); tick();
    for (int i = 0; i < 5; i++) begin
      xs[2] = ~xs[2];
      drive(4'($urandom_range(0, 15)), 1'b0);
      check("hold_data", 32'(out_data), 32'd1);
      check("hold_noack", 32'(ack), 32'd0);
      tick();
    end
    drive(4'b0000, 1'b1);
    check("hold_ack", 32'(ack), 32'b0100);
    check("hold_data_final", 32'(out_data), 32'd1);
    tick();

    // req=1010 with last=1: 3 wins, then 1; sources 0 and 2 never acked.
    do_reset();
    drive(4'b0010, 1'b1); tick();
    drive(4'b0000, 1'b1); tick();
    clear_log();
    for (int i = 0; i < 6; i++) begin drive(4'b1010, 1'b1); tick(); end
    check("alt_count", 32'(ack_vec.size() >= 2), 32'd1);
    if (ack_vec.size() >= 2) begin
      check("alt_first", 32'(ack_vec[0]), 32'b1000);
      check("alt_second", 32'(ack_vec[1]), 32'b0010);
    end
    foreach (ack_vec[i]) check("alt_never_0_2", 32'(ack_vec[i] & 4'b0101), 32'd0);

    // Asynchronous reset in the middle of a transfer.
    do_reset();
    drive(4'b0110, 1'b0); tick();
    drive(4'b0110, 1'b0);
    check("ar_pre_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    check("ar_valid_low", 32'(out_valid), 32'd0);
    check("ar_noack", 32'(ack), 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    check("ar_noack_held", 32'(ack), 32'd0);
    rst_n = 1'b1;
    drive(4'b1100, 1'b1); tick();
    drive(4'b0000, 1'b1);
    check("ar_next_sel", 32'(sel), 32'd2);
    tick();

`ifdef MUX_ARBITER_TIMEOUT_EN
    // Consumer never ready: the grant is dropped 16 cycles after out_valid rises.
    do_reset();
    drive(4'b0011, 1'b0); tick();
    drive(4'b0011, 1'b0);
    check("to_valid", 32'(out_valid), 32'd1);
    n = 0;
    while (n <= 40) begin
      tick(); n++;
      drive(4'b0011, 1'b0);
      if (timeout) break;
    end
    check("to_delay", 32'(n), 32'd16);
    check("to_valid_low", 32'(out_valid), 32'd0);
    tick();
    drive(4'b0011, 1'b0);
    check("to_pulse_once", 32'(timeout), 32'd0);
    check("to_next_sel", 32'(sel), 32'd1);
    tick();
    drive(4'b0000, 1'b1); tick();
`endif

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      for (int j = 0; j < 4; j++) xs[j] = DW'($urandom_range(0, (1 << DW) - 1));
      drive(4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
